pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game-sequencing controller for the VGA pong datapath.
- Owns ball position, ball direction, paddle position and the game state machine.
- Updates all of them exactly once per video frame, at end-of-frame, so the pixel renderer never sees a mid-frame change.
- Outputs (ball_x, ball_y, paddle_x) feed the pixel renderer directly; it replaces free-running counter-based animation with frame-locked sequencing.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- H_LAST, 799, last hPos value of a line.
- V_LAST, 524, last vPos value of a frame.
- RADIUS, 20, ball radius in pixels.
- BALL_STEP, 5, ball pixels per frame per axis.
- PADDLE_W, 100, paddle width.
- PADDLE_Y, 425, paddle top line.
- PADDLE_STEP, 10, paddle pixels per frame.
- LIVES_INIT, 3, lives at game start (1..3).
- MISS_FRAMES, 60, frames spent in MISS.

Ports:
- pixel_clock, in, 1, pixel clock.
- rst, in, 1, reset, synchronous, active-high.
- hPos, in, 10, current horizontal counter.
- vPos, in, 10, current vertical counter.
- btn_left, in, 1, move paddle left (level).
- btn_right, in, 1, move paddle right (level).
- btn_start, in, 1, start / restart (level, edge-detected internally).
- ball_x, out, 10, ball centre x.
- ball_y, out, 10, ball centre y.
- paddle_x, out, 10, paddle left edge.
- lives, out, 2, remaining lives.
- game_state, out, 2, 0=IDLE 1=PLAY 2=MISS 3=OVER.
- frame_tick, out, 1, one-cycle pulse at end of frame.
- score, out, 8, paddle hits (see Optional Feature).

Behaviour:
- Reset, synchronous: state=IDLE, paddle_x=(H_ACTIVE-PADDLE_W)/2=270, ball_x=paddle_x+PADDLE_W/2=320, ball_y=PADDLE_Y-RADIUS=405, dir_x=right, dir_y=up, lives=LIVES_INIT, frame_tick=0, score=0, miss counter=0, start edge register=0. Reset mid-game fully aborts the game in the same edge.
- frame_tick: registered, asserted for the cycle after hPos==H_LAST && vPos==V_LAST. All position/state updates happen only in cycles with frame_tick=1. Outputs are therefore stable for a whole frame, and there is 1-cycle latency from end-of-frame to update.
- start_pulse: btn_start rising edge sampled every clock, latched until consumed at the next frame_tick. A press and release within one frame is not lost.
- Paddle, IDLE and PLAY only:
  - left-only: paddle_x=max(0, paddle_x-PADDLE_STEP).
  - right-only: paddle_x=min(H_ACTIVE-PADDLE_W, paddle_x+PADDLE_STEP).
  - both or none: hold.
  - Arithmetic is 11-bit signed before clamp; no wrap.
- IDLE: ball rides the paddle (ball_x=new paddle_x+PADDLE_W/2, ball_y=PADDLE_Y-RADIUS). start_pulse -> PLAY, dir_y=up, dir_x=right.
- PLAY, evaluated on the current position, then move by BALL_STEP in the updated direction, clamped to [RADIUS, H_ACTIVE-RADIUS] for x and [RADIUS, V_ACTIVE] for y:
  - x<=RADIUS -> right.
  - x>=H_ACTIVE-RADIUS -> left.
  - y<=RADIUS -> down.
  - Paddle hit: dir_y=down && y+RADIUS>=PADDLE_Y && y<PADDLE_Y && paddle_x<=x<paddle_x+PADDLE_W -> up.
  - Miss: dir_y=down && y>=V_ACTIVE-RADIUS without a hit -> MISS, lives-1, miss counter cleared. Miss takes priority over a wall bounce in the same frame.
  - Corner case: simultaneous x and y bounces both apply.
- MISS: ball and paddle frozen; counter increments per tick. At MISS_FRAMES-1: lives==0 -> OVER, else -> IDLE.
- OVER: everything frozen. start_pulse -> IDLE with lives=LIVES_INIT and positions as at reset.
- start_pulse in PLAY or MISS is discarded at that tick.

Optional Feature:
- PONG_SCORE_EN defined: score increments (saturating at 255) on each paddle hit; cleared on reset and on OVER->IDLE.
- Undefined: score is driven constant 0, and no counter logic is synthesised.

Decomposition:
- pong_pkg: game state enum (IDLE/PLAY/MISS/OVER), default timing and geometry constants, direction encoding.
- One sub-module, pong_frame_tick: frame_tick generation plus start edge detect/latch. The FSM and position datapath stay in pong_game_ctrl.

Test Plan:
- Reset then 1 frame, no buttons -> ball (320,405), paddle_x 270, lives 3, state IDLE, exactly one frame_tick per 800*525 clocks.
- Hold btn_left for 30 frames -> paddle_x 0 after frame 27, then holds; ball_x tracks paddle_x+50. Hold both buttons -> no change.
- Start, paddle at 270, no buttons -> PLAY; ball_y falls 5 per frame to 20; dir flips; ball returns; hit at x within [270,370) -> bounces up, score+1 when PONG_SCORE_EN is defined.
- Move paddle to 0 while the ball descends at x>=540 -> MISS when ball_y>=460; lives 2; after 60 frames -> IDLE.
- Three misses -> OVER with lives 0; btn_start pulse of 2 clocks mid-frame -> IDLE at next tick with lives 3.
- Assert rst for 1 cycle while in PLAY -> next cycle all outputs equal reset values.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and default geometry/timing for the pong game controller.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_MISS = 2'd2,
    ST_OVER = 2'd3
  } game_state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_x_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_y_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_LAST      = 799;
  localparam int DEF_V_LAST      = 524;
  localparam int DEF_RADIUS      = 20;
  localparam int DEF_BALL_STEP   = 5;
  localparam int DEF_PADDLE_W    = 100;
  localparam int DEF_PADDLE_Y    = 425;
  localparam int DEF_PADDLE_STEP = 10;
  localparam int DEF_LIVES_INIT  = 3;
  localparam int DEF_MISS_FRAMES = 60;

endpackage

// File: rtl/pong_frame_tick.sv
// End-of-frame tick generation and start-button edge capture.
// The start press is held until the next frame tick so a short press is never lost.
module pong_frame_tick
  import pong_pkg::*;
#(
  parameter int H_LAST = DEF_H_LAST,
  parameter int V_LAST = DEF_V_LAST
) (
  input  logic       pixel_clock,
  input  logic       rst,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  input  logic       btn_start,
  output logic       frame_tick,
  output logic       start_pulse
);

  logic start_prev;

  // Tick follows the last pixel of the frame; start latch is consumed by every tick.
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      frame_tick  <= 1'b0;
      start_prev  <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      frame_tick  <= (hPos == 10'(H_LAST)) && (vPos == 10'(V_LAST));
      start_prev  <= btn_start;
      start_pulse <= (start_pulse && !frame_tick) || (btn_start && !start_prev);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-locked pong sequencer: game FSM, ball and paddle positions.
// All state changes happen only on frame_tick, so outputs are stable per frame.
// Build option: define PONG_SCORE_EN to enable the paddle-hit score counter.
//
// state | meaning
// IDLE  | ball rides paddle, waiting for start
// PLAY  | ball moving, bounces and paddle hits evaluated
// MISS  | ball/paddle frozen for MISS_FRAMES ticks after a miss
// OVER  | no lives left, frozen until start
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_LAST      = DEF_H_LAST,
  parameter int V_LAST      = DEF_V_LAST,
  parameter int RADIUS      = DEF_RADIUS,
  parameter int BALL_STEP   = DEF_BALL_STEP,
  parameter int PADDLE_W    = DEF_PADDLE_W,
  parameter int PADDLE_Y    = DEF_PADDLE_Y,
  parameter int PADDLE_STEP = DEF_PADDLE_STEP,
  parameter int LIVES_INIT  = DEF_LIVES_INIT,
  parameter int MISS_FRAMES = DEF_MISS_FRAMES
) (
  input  logic       pixel_clock,
  input  logic       rst,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_x,
  output logic [1:0] lives,
  output logic [1:0] game_state,
  output logic       frame_tick,
  output logic [7:0] score
);

  localparam int MW = $clog2(MISS_FRAMES);

  localparam logic [10:0] X_MIN  = 11'(RADIUS);
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - RADIUS);
  localparam logic [10:0] Y_MIN  = 11'(RADIUS);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE);
  localparam logic [10:0] Y_MISS = 11'(V_ACTIVE - RADIUS);
  localparam logic [10:0] STEP   = 11'(BALL_STEP);
  localparam logic [10:0] RAD    = 11'(RADIUS);
  localparam logic [10:0] PAD_Y  = 11'(PADDLE_Y);
  localparam logic [10:0] PAD_W  = 11'(PADDLE_W);

  localparam logic signed [10:0] PAD_MAX  = 11'(H_ACTIVE - PADDLE_W);
  localparam logic signed [10:0] PAD_STEP = 11'(PADDLE_STEP);

  localparam logic [9:0] PADDLE_X0 = 10'((H_ACTIVE - PADDLE_W) / 2);
  localparam logic [9:0] HALF_W    = 10'(PADDLE_W / 2);
  localparam logic [9:0] BALL_X0   = 10'((H_ACTIVE - PADDLE_W) / 2 + PADDLE_W / 2);
  localparam logic [9:0] BALL_Y0   = 10'(PADDLE_Y - RADIUS);

  game_state_t    state;
  dir_x_t         dir_x, dir_x_upd;
  dir_y_t         dir_y, dir_y_upd;
  logic [MW-1:0]  miss_cnt;
  logic           start_pulse;
  logic           hit, miss;
  logic [10:0]    bx, by, px;
  logic [9:0]     bx_next, by_next, paddle_next;
  logic signed [10:0] pad_dec, pad_inc;

  pong_frame_tick #(
    .H_LAST (H_LAST),
    .V_LAST (V_LAST)
  ) u_frame_tick (
    .pixel_clock (pixel_clock),
    .rst         (rst),
    .hPos        (hPos),
    .vPos        (vPos),
    .btn_start   (btn_start),
    .frame_tick  (frame_tick),
    .start_pulse (start_pulse)
  );

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign px = {1'b0, paddle_x};
  assign game_state = state;

  // Paddle step with clamping done in signed 11-bit so a left move never wraps.
  always_comb begin
    pad_dec     = signed'(px) - PAD_STEP;
    pad_inc     = signed'(px) + PAD_STEP;
    paddle_next = paddle_x;
    if (btn_left && !btn_right)
      paddle_next = pad_dec[10] ? 10'd0 : pad_dec[9:0];
    else if (btn_right && !btn_left)
      paddle_next = (pad_inc > PAD_MAX) ? 10'(PAD_MAX) : pad_inc[9:0];
  end

  // Bounce/hit/miss decisions on the current position, then one clamped step.
  always_comb begin
    dir_x_upd = dir_x;
    if (bx <= X_MIN)      dir_x_upd = DIR_RIGHT;
    else if (bx >= X_MAX) dir_x_upd = DIR_LEFT;

    hit  = (dir_y == DIR_DOWN) && (by + RAD >= PAD_Y) && (by < PAD_Y) &&
           (bx >= px) && (bx < px + PAD_W);
    miss = (dir_y == DIR_DOWN) && (by >= Y_MISS) && !hit;

    dir_y_upd = dir_y;
    if (by <= Y_MIN) dir_y_upd = DIR_DOWN;
    if (hit)         dir_y_upd = DIR_UP;

    if (dir_x_upd == DIR_RIGHT)
      bx_next = (bx + STEP > X_MAX) ? 10'(X_MAX) : 10'(bx + STEP);
    else
      bx_next = (bx < X_MIN + STEP) ? 10'(X_MIN) : 10'(bx - STEP);

    if (dir_y_upd == DIR_DOWN)
      by_next = (by + STEP > Y_MAX) ? 10'(Y_MAX) : 10'(by + STEP);
    else
      by_next = (by < Y_MIN + STEP) ? 10'(Y_MIN) : 10'(by - STEP);
  end

  // Game FSM and position registers, advanced once per frame tick.
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      state    <= ST_IDLE;
      paddle_x <= PADDLE_X0;
      ball_x   <= BALL_X0;
      ball_y   <= BALL_Y0;
      dir_x    <= DIR_RIGHT;
      dir_y    <= DIR_UP;
      lives    <= 2'(LIVES_INIT);
      miss_cnt <= '0;
    end else if (frame_tick) begin
      case (state)
        ST_IDLE: begin
          paddle_x <= paddle_next;
          ball_x   <= paddle_next + HALF_W;
          ball_y   <= BALL_Y0;
          if (start_pulse) begin
            state <= ST_PLAY;
            dir_x <= DIR_RIGHT;
            dir_y <= DIR_UP;
          end
        end
        ST_PLAY: begin
          paddle_x <= paddle_next;
          if (miss) begin
            state    <= ST_MISS;
            lives    <= lives - 2'd1;
            miss_cnt <= '0;
          end else begin
            dir_x  <= dir_x_upd;
            dir_y  <= dir_y_upd;
            ball_x <= bx_next;
            ball_y <= by_next;
          end
        end
        ST_MISS: begin
          if (miss_cnt == MW'(MISS_FRAMES - 1)) begin
            miss_cnt <= '0;
            state    <= (lives == 2'd0) ? ST_OVER : ST_IDLE;
          end else begin
            miss_cnt <= miss_cnt + MW'(1);
          end
        end
        ST_OVER: begin
          if (start_pulse) begin
            state    <= ST_IDLE;
            paddle_x <= PADDLE_X0;
            ball_x   <= BALL_X0;
            ball_y   <= BALL_Y0;
            dir_x    <= DIR_RIGHT;
            dir_y    <= DIR_UP;
            lives    <= 2'(LIVES_INIT);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PONG_SCORE_EN
  logic [7:0] score_q;

  // Saturating paddle-hit counter, cleared when a new game starts from OVER.
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      score_q <= '0;
    end else if (frame_tick) begin
      if (state == ST_PLAY && hit && score_q != 8'hFF)
        score_q <= score_q + 8'd1;
      else if (state == ST_OVER && start_pulse)
        score_q <= '0;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: each issued frame pushes its expected
// outputs; a monitor pops and compares after every frame_tick update.
// Frames are compressed by driving hPos/vPos straight to the last position.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

  localparam int S_IDLE = 0, S_PLAY = 1, S_MISS = 2, S_OVER = 3;
`ifdef PONG_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  typedef struct {
    int bx; int by; int px; int lv; int st; int sc;
  } exp_t;

  logic       pixel_clock = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hPos = '0, vPos = '0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
  logic [9:0] ball_x, ball_y, paddle_x;
  logic [1:0] lives, game_state;
  logic       frame_tick;
  logic [7:0] score;

  int   n_checks = 0;
  int   n_errors = 0;
  int   ticks_seen = 0;
  int   frames_issued = 0;
  int   frame_no = 0;
  exp_t exp_q[$];

  pong_game_ctrl dut (
    .pixel_clock (pixel_clock),
    .rst         (rst),
    .hPos        (hPos),
    .vPos        (vPos),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_start   (btn_start),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .paddle_x    (paddle_x),
    .lives       (lives),
    .game_state  (game_state),
    .frame_tick  (frame_tick),
    .score       (score)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s (frame %0d): got %0d, expected %0d", name, frame_no, act, expv);
    end
  endtask

  function automatic exp_t mk(input int bx, by, px, lv, st, sc);
    exp_t e;
    e.bx = bx; e.by = by; e.px = px; e.lv = lv; e.st = st;
    e.sc = SCORE_ON ? sc : 0;
    return e;
  endfunction

  // Game 1 trajectory from (320,405), with a paddle hit at frame 155.
  function automatic int g1_x(input int k);
    if (k <= 60)  return 320 + 5*k;
    if (k <= 180) return 620 - 5*(k-60);
    if (k <= 300) return 20 + 5*(k-180);
    return 620 - 5*(k-300);
  endfunction
  function automatic int g1_y(input int k);
    if (k <= 77)  return 405 - 5*k;
    if (k <= 154) return 20 + 5*(k-77);
    if (k <= 231) return 400 - 5*(k-155);
    return 20 + 5*(k-231);
  endfunction
  function automatic int g1_p(input int k);
    if (k <= 17)  return 270 - 10*k;
    if (k <= 200) return 100;
    if (k <= 210) return 100 - 10*(k-200);
    return 0;
  endfunction
  // Games 2/3 trajectory from (50,405), paddle parked at 0.
  function automatic int g2_x(input int k);
    if (k <= 114) return 50 + 5*k;
    return 620 - 5*(k-114);
  endfunction
  function automatic int g2_y(input int k);
    if (k <= 77) return 405 - 5*k;
    return 20 + 5*(k-77);
  endfunction

  task automatic do_frame(input exp_t e);
    exp_q.push_back(e);
    frames_issued++;
    @(negedge pixel_clock); hPos = 10'd799; vPos = 10'd524;
    @(negedge pixel_clock); hPos = 10'd0;   vPos = 10'd0;
    @(negedge pixel_clock);
    @(negedge pixel_clock);
  endtask

  task automatic press_start();
    @(negedge pixel_clock); btn_start = 1'b1;
    @(negedge pixel_clock);
    @(negedge pixel_clock); btn_start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ball_x"},     ball_x,     320);
    check({tag, "_ball_y"},     ball_y,     405);
    check({tag, "_paddle_x"},   paddle_x,   270);
    check({tag, "_lives"},      lives,      3);
    check({tag, "_state"},      game_state, S_IDLE);
    check({tag, "_frame_tick"}, frame_tick, 0);
    check({tag, "_score"},      score,      0);
  endtask

  // Monitor: after each tick, compare the updated outputs with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge pixel_clock);
      if (frame_tick === 1'b1) begin
        ticks_seen++;
        @(negedge pixel_clock);
        frame_no++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_tick (frame %0d): got a tick, expected none", frame_no);
        end else begin
          e = exp_q.pop_front();
          check("ball_x",   ball_x,     e.bx);
          check("ball_y",   ball_y,     e.by);
          check("paddle_x", paddle_x,   e.px);
          check("lives",    lives,      e.lv);
          check("state",    game_state, e.st);
          check("score",    score,      e.sc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lv;
    repeat (3) @(negedge pixel_clock);
    rst = 1'b0;
    @(negedge pixel_clock);
    check_reset_values("reset");

    // Near-miss counter positions must not tick.
    @(negedge pixel_clock); hPos = 10'd799; vPos = 10'd523;
    @(negedge pixel_clock); hPos = 10'd798; vPos = 10'd524;
    @(negedge pixel_clock); hPos = 10'd0;   vPos = 10'd0;
    @(negedge pixel_clock);
    check("no_tick_off_corner", ticks_seen, 0);

    do_frame(mk(320, 405, 270, 3, S_IDLE, 0));

    btn_left = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      int p;
      p = (270 - 10*k < 0) ? 0 : 270 - 10*k;
      do_frame(mk(p + 50, 405, p, 3, S_IDLE, 0));
    end
    btn_right = 1'b1;
    for (int k = 1; k <= 2; k++) do_frame(mk(50, 405, 0, 3, S_IDLE, 0));
    btn_left = 1'b0;
    for (int k = 1; k <= 27; k++) do_frame(mk(10*k + 50, 405, 10*k, 3, S_IDLE, 0));
    btn_right = 1'b0;

    // Game 1: start, hit at frame 155, then a miss at frame 320.
    press_start();
    do_frame(mk(320, 405, 270, 3, S_PLAY, 0));
    for (int k = 1; k <= 320; k++) begin
      btn_left = (k <= 17) || (k >= 201 && k <= 210);
      if (k < 320)
        do_frame(mk(g1_x(k), g1_y(k), g1_p(k), 3, S_PLAY, (k >= 155) ? 1 : 0));
      else
        do_frame(mk(g1_x(319), g1_y(319), 0, 2, S_MISS, 1));
    end
    btn_left = 1'b0;
    btn_right = 1'b1;
    for (int j = 1; j <= 60; j++)
      do_frame(mk(525, 460, 0, 2, (j < 60) ? S_MISS : S_IDLE, 1));
    btn_right = 1'b0;
    do_frame(mk(50, 405, 0, 2, S_IDLE, 1));

    // Games 2 and 3: paddle parked at 0, ball always missed.
    lv = 2;
    for (int g = 0; g < 2; g++) begin
      press_start();
      do_frame(mk(50, 405, 0, lv, S_PLAY, 1));
      for (int k = 1; k <= 166; k++) begin
        if (k == 10) press_start();
        if (k < 166) do_frame(mk(g2_x(k), g2_y(k), 0, lv, S_PLAY, 1));
        else         do_frame(mk(365, 460, 0, lv - 1, S_MISS, 1));
      end
      for (int j = 1; j <= 60; j++)
        do_frame(mk(365, 460, 0, lv - 1,
                    (j < 60) ? S_MISS : ((lv - 1 == 0) ? S_OVER : S_IDLE), 1));
      if (lv - 1 != 0) do_frame(mk(50, 405, 0, lv - 1, S_IDLE, 1));
      lv = lv - 1;
    end

    btn_left = 1'b1;
    do_frame(mk(365, 460, 0, 0, S_OVER, 1));
    btn_left = 1'b0;
    press_start();
    do_frame(mk(320, 405, 270, 3, S_IDLE, 0));

    btn_right = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      int p;
      p = (270 + 10*k > 540) ? 540 : 270 + 10*k;
      do_frame(mk(p + 50, 405, p, 3, S_IDLE, 0));
    end
    btn_right = 1'b0;
    press_start();
    do_frame(mk(590, 405, 540, 3, S_PLAY, 0));
    for (int k = 1; k <= 3; k++)
      do_frame(mk(590 + 5*k, 405 - 5*k, 540, 3, S_PLAY, 0));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge pixel_clock);
    check("queue_drained", exp_q.size(), 0);
    check("tick_count", ticks_seen, frames_issued);

    @(negedge pixel_clock); rst = 1'b1;
    @(negedge pixel_clock); rst = 1'b0;
    check_reset_values("midgame_reset");
    do_frame(mk(320, 405, 270, 3, S_IDLE, 0));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge pixel_clock);
    check("final_queue_drained", exp_q.size(), 0);
    check("final_tick_count", ticks_seen, frames_issued);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
